osc_monitor: RTL and testbench

Checks that a free-running clock source actually runs, and measures how fast. It counts rising edges of an asynchronous `sig_in` over a fixed gate window of `clk` cycles. It reports the edge count once per window, plus range, alive and overflow flags. It sits downstream of an oscillator (internal HFOSC or external board oscillator) as its health checker, and its flags drive status LEDs or fallback logic.

---
 rtl/osc_monitor.sv | 166 ++++++++++++++++
 tb/tb_osc_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_monitor.sv
// rtl/osc_monitor.sv - gated edge counter that checks a free-running clock is alive and in range
module osc_monitor #(
    parameter int          GATE_CYCLES = 48000,
    parameter int          CNT_W       = 16,
    parameter int unsigned MIN_COUNT   = 11000,
    parameter int unsigned MAX_COUNT   = 13000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             alive,
    output logic             overflow
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_COUNT);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       arm_cnt_q, arm_cnt_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_bit_q, ovf_bit_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_valid_q, count_valid_d;
    logic             in_range_q, in_range_d;
    logic             alive_q, alive_d;
    logic             overflow_q, overflow_d;

    logic             sig_edge;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;

    // Rising-edge detect on the synchronized input, and the saturating "count plus this edge" value
    always_comb begin
        sync1_d  = sig_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        sig_edge = sync2_q & ~sync3_q;
        if (sig_edge && (edge_cnt_q != CNT_MAX)) begin
            cnt_inc = edge_cnt_q + 1'b1;
        end else begin
            cnt_inc = edge_cnt_q;
        end
        ovf_inc = ovf_bit_q | (sig_edge & (edge_cnt_q == CNT_MAX));
    end

    // Measurement sequencer: idle, synchronizer flush, then back-to-back gate windows
    always_comb begin
        state_d       = state_q;
        arm_cnt_d     = arm_cnt_q;
        gate_d        = gate_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_bit_d     = ovf_bit_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        in_range_d    = in_range_q;
        alive_d       = alive_q;
        overflow_d    = overflow_q;
        case (state_q)
            ST_IDLE: begin
                arm_cnt_d  = 2'd0;
                gate_d     = '0;
                edge_cnt_d = '0;
                ovf_bit_d  = 1'b0;
                if (enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                gate_d     = '0;
                edge_cnt_d = '0;
                ovf_bit_d  = 1'b0;
                if (!enable) begin
                    state_d   = ST_IDLE;
                    arm_cnt_d = 2'd0;
                end else if (arm_cnt_q == 2'd2) begin
                    state_d   = ST_MEASURE;
                    arm_cnt_d = 2'd0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 2'd1;
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    // Abandon the partial window; published results stay as they were
                    state_d    = ST_IDLE;
                    gate_d     = '0;
                    edge_cnt_d = '0;
                    ovf_bit_d  = 1'b0;
                end else if (gate_q == GATE_LAST) begin
                    count_d       = cnt_inc;
                    overflow_d    = ovf_inc;
                    alive_d       = (cnt_inc != '0);
                    in_range_d    = (cnt_inc >= MIN_C) && (cnt_inc <= MAX_C) && !ovf_inc;
                    count_valid_d = 1'b1;
                    gate_d        = '0;
                    edge_cnt_d    = '0;
                    ovf_bit_d     = 1'b0;
                end else begin
                    gate_d     = gate_q + 1'b1;
                    edge_cnt_d = cnt_inc;
                    ovf_bit_d  = ovf_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state, synchronizer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            arm_cnt_q     <= 2'd0;
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            ovf_bit_q     <= 1'b0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            in_range_q    <= 1'b0;
            alive_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            gate_q        <= gate_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_bit_q     <= ovf_bit_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            in_range_q    <= in_range_d;
            alive_q       <= alive_d;
            overflow_q    <= overflow_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign in_range    = in_range_q;
    assign alive       = alive_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_osc_monitor.sv
// tb/tb_osc_monitor.sv - self-checking bench for osc_monitor
module tb_osc_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sig_in;
    logic [7:0] count_a;
    logic       cv_a, inr_a, alive_a, ovf_a;
    logic [3:0] count_b;
    logic       cv_b, inr_b, alive_b, ovf_b;

    always #5 clk = ~clk;

    osc_monitor #(.GATE_CYCLES(100), .CNT_W(8), .MIN_COUNT(20), .MAX_COUNT(30)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .count(count_a), .count_valid(cv_a), .in_range(inr_a), .alive(alive_a), .overflow(ovf_a)
    );

    osc_monitor #(.GATE_CYCLES(100), .CNT_W(4), .MIN_COUNT(11), .MAX_COUNT(13)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .count(count_b), .count_valid(cv_b), .in_range(inr_b), .alive(alive_b), .overflow(ovf_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Waits for a count_valid pulse on dut_a; cyc = negedges waited, or -1 on timeout
    task automatic wait_pulse(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cv_a) return;
        end
        cyc = -1;
    endtask

    // Stimulus source: periodic (mode 0) or randomly jittered period 5..8 clk (mode 1)
    int gen_mode = 0;
    int period   = 0;
    int high     = 0;
    int tb_edges = 0;
    initial begin
        int p, hd, ld;
        sig_in = 1'b0;
        #3;
        forever begin
            if (gen_mode == 1) begin
                p  = int'($urandom_range(5, 8));
                hd = (p / 2) * 10 - 2 + int'($urandom_range(0, 4));
                ld = p * 10 - (p / 2) * 10 - 2 + int'($urandom_range(0, 4));
                sig_in = 1'b1;
                tb_edges++;
                #(hd);
                sig_in = 1'b0;
                #(ld);
            end else if (period == 0) begin
                sig_in = 1'b0;
                #10;
            end else begin
                sig_in = 1'b1;
                tb_edges++;
                #(high * 10);
                sig_in = 1'b0;
                #((period - high) * 10);
            end
        end
    end

    // Longest run of consecutive count_valid samples
    int cv_run = 0;
    int cv_max_run = 0;
    always @(negedge clk) begin
        if (cv_a) begin
            cv_run = cv_run + 1;
            if (cv_run > cv_max_run) cv_max_run = cv_run;
        end else begin
            cv_run = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int period;
        int high;
        int a_cnt;
        int a_inr;
        int a_alive;
        int b_cnt;
        int b_ovf;
        int b_inr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, cvs, sum, snap0, snap1;
        vecs[0] = '{4,  2,  25, 1, 1, 15, 1, 0};
        vecs[1] = '{10, 5,  10, 0, 1, 10, 0, 0};
        vecs[2] = '{0,  0,  0,  0, 0, 0,  0, 0};
        vecs[3] = '{5,  2,  20, 1, 1, 15, 1, 0};
        vecs[4] = '{20, 10, 5,  0, 1, 5,  0, 0};
        vecs[5] = '{4,  2,  25, 1, 1, 15, 1, 0};

        // Reset state
        rst_n  = 1'b0;
        enable = 1'b0;
        period = 4;
        high   = 2;
        repeat (5) @(negedge clk);
        check("rst_count", int'(count_a), 0);
        check("rst_valid", int'(cv_a), 0);
        check("rst_in_range", int'(inr_a), 0);
        check("rst_alive", int'(alive_a), 0);
        check("rst_overflow", int'(ovf_a), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_valid", int'(cv_a), 0);

        // First pulse latency after enable
        enable = 1'b1;
        wait_pulse(200, cyc);
        check_range("first_latency", cyc, 103, 105);
        check("first_count", int'(count_a), 25);

        // Table of steady-state windows for both counter widths
        for (int i = 0; i < 6; i++) begin
            period = vecs[i].period;
            high   = vecs[i].high;
            wait_pulse(150, cyc);
            check("settle_pulse_seen", int'(cyc > 0), 1);
            wait_pulse(150, cyc);
            check("window_interval", cyc, 100);
            check("a_count", int'(count_a), vecs[i].a_cnt);
            check("a_in_range", int'(inr_a), vecs[i].a_inr);
            check("a_alive", int'(alive_a), vecs[i].a_alive);
            check("a_overflow", int'(ovf_a), 0);
            check("b_valid", int'(cv_b), 1);
            check("b_count", int'(count_b), vecs[i].b_cnt);
            check("b_overflow", int'(ovf_b), vecs[i].b_ovf);
            check("b_in_range", int'(inr_b), vecs[i].b_inr);
            check("b_alive", int'(alive_b), vecs[i].a_alive);
        end

        // Drop enable mid-window: no pulse, outputs hold
        repeat (50) @(negedge clk);
        enable = 1'b0;
        cvs = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (cv_a) cvs++;
        end
        check("abort_no_valid", cvs, 0);
        check("hold_count", int'(count_a), 25);
        check("hold_in_range", int'(inr_a), 1);
        check("hold_alive", int'(alive_a), 1);
        check("hold_overflow", int'(ovf_a), 0);
        enable = 1'b1;
        wait_pulse(200, cyc);
        check_range("reenable_latency", cyc, 103, 105);
        check("reenable_count", int'(count_a), 25);

        // Asynchronous reset mid-window
        repeat (40) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(count_a), 0);
        check("async_rst_valid", int'(cv_a), 0);
        check("async_rst_in_range", int'(inr_a), 0);
        check("async_rst_alive", int'(alive_a), 0);
        check("async_rst_overflow", int'(ovf_b), 0);
        check("async_rst_count_b", int'(count_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pulse(200, cyc);
        check_range("post_rst_latency", cyc, 103, 105);
        check("post_rst_count", int'(count_a), 25);

        // Jittered input: window sums conserve driven edges
        gen_mode = 1;
        wait_pulse(150, cyc);
        check("rand_settle_seen", int'(cyc > 0), 1);
        snap0 = tb_edges;
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            wait_pulse(150, cyc);
            check("rand_interval", cyc, 100);
            check_range("rand_window_count", int'(count_a), 100 / 8 - 1, 100 / 5 + 1);
            sum += int'(count_a);
        end
        snap1 = tb_edges;
        check_range("rand_sum10", sum, snap1 - snap0 - 1, snap1 - snap0 + 1);
        check("valid_width", cv_max_run, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
